// File: rtl/cfeb_sched_pkg.sv
// Shared defaults and types for the CFEB SCA block scheduler.
// Holds the PEND entry layout and the round-robin free-block search.
package cfeb_sched_pkg;

    localparam int NBLK = 16;
    localparam int BW   = 4;
    localparam int WIN  = 3;
    localparam int TSW  = 10;

    typedef struct packed {
        logic [BW-1:0]  blk;
        logic [TSW-1:0] ts;
    } pend_t;

    // First set bit of free, searching upward from cur+1 and wrapping.
    function automatic logic [BW-1:0] rr_pick(
        input logic [NBLK-1:0] free,
        input logic [BW-1:0]   cur
    );
        logic [BW-1:0] pick;
        logic [BW-1:0] idx;
        logic          found;
        pick  = cur;
        found = 1'b0;
        for (int i = 1; i <= NBLK; i++) begin
            idx = cur + BW'(i);
            if (!found && free[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/blk_fifo.sv
// Small synchronous FIFO used for the PEND and RDQ block queues.
// Push and pop are ignored when full or empty respectively.
module blk_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    // Storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sca_blk_sched.sv
// SCA block scheduler: write-block rotation, LCT locking, L1A matching,
// readout queueing and expiry of unmatched blocks for one CFEB.
module sca_blk_sched #(
    parameter int NBLK = cfeb_sched_pkg::NBLK,
    parameter int BW   = cfeb_sched_pkg::BW,
    parameter int WIN  = cfeb_sched_pkg::WIN,
    parameter int TSW  = cfeb_sched_pkg::TSW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_ADV,
    input  logic          LCT,
    input  logic          L1A,
    input  logic [7:0]    L1A_DLY,
    input  logic          RD_DONE,
    output logic [BW-1:0] WBLK,
    output logic          RD_VLD,
    output logic [BW-1:0] RD_BLK,
    output logic [BW:0]   NFREE,
    output logic          FULL,
    output logic          LCT_DROP,
    output logic          L1A_NOMATCH
);

    import cfeb_sched_pkg::pend_t;
    import cfeb_sched_pkg::rr_pick;

    localparam logic [TSW-1:0] WIN_T = TSW'(WIN);

    logic [BW-1:0]   wblk_q, wblk_d;
    logic [NBLK-1:0] free_q, free_d;
    logic [BW:0]     nfree_q, nfree_d;
    logic [TSW-1:0]  ts_q;
    logic            drop_q, nom_q;

    pend_t           pend_in, pend_head;
    logic            pend_empty, pend_full;
    logic [BW-1:0]   rdq_head;
    logic            rdq_empty, rdq_full;

    logic [TSW-1:0]  dly_t, lo, hi, age;
    logic            match, expire, pend_pop;
    logic            lct_ok, adv, ret_w, rd_pop;
    logic [BW-1:0]   nxt;

    assign dly_t = TSW'(L1A_DLY);
    assign hi    = dly_t + WIN_T;
    assign lo    = (dly_t >= WIN_T) ? dly_t - WIN_T : '0;
    assign age   = ts_q - pend_head.ts;

    assign match    = L1A && !pend_empty && !rdq_full
                      && (age >= lo) && (age <= hi);
    assign expire   = !pend_empty && !match && (age > hi);
    assign pend_pop = match || expire;

    assign lct_ok = LCT && (nfree_q != '0) && !pend_full;
    assign adv    = (WR_ADV || lct_ok) && (nfree_q != '0);
    assign ret_w  = adv && !lct_ok;
    assign rd_pop = RD_DONE && !rdq_empty;
    assign nxt    = rr_pick(free_q, wblk_q);

    assign pend_in.blk = wblk_q;
    assign pend_in.ts  = ts_q;

    blk_fifo #(.W($bits(pend_t)), .DEPTH(NBLK)) u_pend (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (lct_ok),
        .pop_i   (pend_pop),
        .din_i   (pend_in),
        .dout_o  (pend_head),
        .empty_o (pend_empty),
        .full_o  (pend_full)
    );

    blk_fifo #(.W(BW), .DEPTH(NBLK)) u_rdq (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (match),
        .pop_i   (rd_pop),
        .din_i   (pend_head.blk),
        .dout_o  (rdq_head),
        .empty_o (rdq_empty),
        .full_o  (rdq_full)
    );

    // Allocation, returns to the free pool and the free count.
    always_comb begin
        free_d  = free_q;
        wblk_d  = wblk_q;
        if (adv) begin
            free_d[nxt] = 1'b0;
            wblk_d      = nxt;
        end
        if (ret_w) begin
            free_d[wblk_q] = 1'b1;
        end
        if (expire) begin
            free_d[pend_head.blk] = 1'b1;
        end
        if (rd_pop) begin
            free_d[rdq_head] = 1'b1;
        end
        nfree_d = nfree_q + (BW+1)'(ret_w) + (BW+1)'(expire)
                  + (BW+1)'(rd_pop) - (BW+1)'(adv);
    end

    // Block state, timestamp and event pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wblk_q  <= '0;
            free_q  <= {{(NBLK-1){1'b1}}, 1'b0};
            nfree_q <= (BW+1)'(NBLK-1);
            ts_q    <= '0;
            drop_q  <= 1'b0;
            nom_q   <= 1'b0;
        end else begin
            wblk_q  <= wblk_d;
            free_q  <= free_d;
            nfree_q <= nfree_d;
            ts_q    <= ts_q + 1'b1;
            drop_q  <= LCT && (nfree_q == '0);
            nom_q   <= L1A && !match;
        end
    end

    assign WBLK        = wblk_q;
    assign NFREE       = nfree_q;
    assign FULL        = (nfree_q == '0);
    assign RD_VLD      = !rdq_empty;
    assign RD_BLK      = rdq_empty ? '0 : rdq_head;
    assign LCT_DROP    = drop_q;
    assign L1A_NOMATCH = nom_q;

endmodule

// File: tb/tb_sca_blk_sched.sv
// Testbench for sca_blk_sched: directed tables, hand sequences and a
// random run checked against a queue-based block-pool model.
module tb_sca_blk_sched;

    localparam int NBLK = 16;
    localparam int BW   = 4;
    localparam int WIN  = 3;
    localparam int TSW  = 10;

    logic          CLK = 1'b0;
    logic          RST, WR_ADV, LCT, L1A, RD_DONE;
    logic [7:0]    L1A_DLY;
    logic [BW-1:0] WBLK, RD_BLK;
    logic          RD_VLD, FULL, LCT_DROP, L1A_NOMATCH;
    logic [BW:0]   NFREE;

    int ntests = 0;
    int nfail  = 0;

    sca_blk_sched dut (
        .CLK         (CLK),
        .RST         (RST),
        .WR_ADV      (WR_ADV),
        .LCT         (LCT),
        .L1A         (L1A),
        .L1A_DLY     (L1A_DLY),
        .RD_DONE     (RD_DONE),
        .WBLK        (WBLK),
        .RD_VLD      (RD_VLD),
        .RD_BLK      (RD_BLK),
        .NFREE       (NFREE),
        .FULL        (FULL),
        .LCT_DROP    (LCT_DROP),
        .L1A_NOMATCH (L1A_NOMATCH)
    );

    always #5 CLK = ~CLK;

    // Reference pool: a set of free blocks and two ordered lists.
    bit m_free [NBLK];
    int m_wblk;
    int m_ts;
    int m_pb [$];
    int m_pt [$];
    int m_rdq [$];
    bit m_drop, m_nom;

    function automatic int m_nfree();
        int n = 0;
        foreach (m_free[i]) n += int'(m_free[i]);
        return n;
    endfunction

    task automatic model_reset();
        foreach (m_free[i]) m_free[i] = (i != 0);
        m_wblk = 0;
        m_ts   = 0;
        m_pb.delete();
        m_pt.delete();
        m_rdq.delete();
        m_drop = 0;
        m_nom  = 0;
    endtask

    task automatic model_step(input bit wr, input bit lct, input bit l1a,
                              input bit rdd, input bit rst);
        bit snap [NBLK];
        int nf, age, lo, hi, nxt, dly, b;
        bit match, expire, lct_ok;
        if (rst) begin
            model_reset();
            return;
        end
        snap = m_free;
        nf   = m_nfree();
        dly  = int'(L1A_DLY);
        lo   = (dly > WIN) ? dly - WIN : 0;
        hi   = dly + WIN;
        age  = 0;
        if (m_pb.size() > 0)
            age = (m_ts - m_pt[0] + (1 << TSW)) % (1 << TSW);
        match  = l1a && m_pb.size() > 0 && age >= lo && age <= hi;
        expire = m_pb.size() > 0 && !match && age > hi;
        lct_ok = lct && nf > 0;
        m_drop = lct && nf == 0;
        m_nom  = l1a && !match;
        if (rdd && m_rdq.size() > 0) begin
            b = m_rdq.pop_front();
            m_free[b] = 1;
        end
        if (match) begin
            b = m_pb.pop_front();
            void'(m_pt.pop_front());
            m_rdq.push_back(b);
        end
        if (expire) begin
            b = m_pb.pop_front();
            void'(m_pt.pop_front());
            m_free[b] = 1;
        end
        if ((wr || lct_ok) && nf > 0) begin
            nxt = m_wblk;
            for (int j = NBLK; j >= 1; j--)
                if (snap[(m_wblk + j) % NBLK]) nxt = (m_wblk + j) % NBLK;
            if (lct_ok) begin
                m_pb.push_back(m_wblk);
                m_pt.push_back(m_ts);
            end else begin
                m_free[m_wblk] = 1;
            end
            m_free[nxt] = 0;
            m_wblk = nxt;
        end
        m_ts = (m_ts + 1) % (1 << TSW);
    endtask

    task automatic check_model(input string tag);
        int eb, nf;
        bit ev;
        eb = (m_rdq.size() > 0) ? m_rdq[0] : 0;
        ev = m_rdq.size() > 0;
        nf = m_nfree();
        ntests++;
        if (WBLK !== BW'(m_wblk) || NFREE !== (BW+1)'(nf)
            || FULL !== (nf == 0) || RD_VLD !== ev
            || RD_BLK !== BW'(eb) || LCT_DROP !== m_drop
            || L1A_NOMATCH !== m_nom) begin
            nfail++;
            $display("FAIL %s model: got wblk=%0d nfree=%0d full=%0b vld=%0b blk=%0d drop=%0b nom=%0b want wblk=%0d nfree=%0d full=%0b vld=%0b blk=%0d drop=%0b nom=%0b",
                     tag, WBLK, NFREE, FULL, RD_VLD, RD_BLK, LCT_DROP,
                     L1A_NOMATCH, m_wblk, nf, nf == 0, ev, eb, m_drop,
                     m_nom);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit wr, input bit lct, input bit l1a,
                        input bit rdd, input bit rst, input string tag);
        WR_ADV  = wr;
        LCT     = lct;
        L1A     = l1a;
        RD_DONE = rdd;
        RST     = rst;
        @(posedge CLK);
        model_step(wr, lct, l1a, rdd, rst);
        #1;
        WR_ADV  = 0;
        LCT     = 0;
        L1A     = 0;
        RD_DONE = 0;
        RST     = 0;
        check_model(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_reset(input int dly);
        L1A_DLY = 8'(dly);
        step(0, 0, 0, 0, 1, "reset");
        step(0, 0, 0, 0, 1, "reset");
    endtask

    typedef struct {
        bit wr, lct, l1a, rdd;
        int wblk, nfree, vld, drop, nom;
    } vec_t;

    vec_t tbl [7];

    initial begin
        RST = 1; WR_ADV = 0; LCT = 0; L1A = 0; RD_DONE = 0;
        L1A_DLY = 8'd100;
        model_reset();

        tbl[0] = '{1, 0, 0, 0, 1, 15, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 2, 15, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 3, 15, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 0, 3, 15, 0, 0, 1};
        tbl[4] = '{0, 1, 0, 0, 4, 14, 0, 0, 0};
        tbl[5] = '{1, 1, 0, 0, 5, 13, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 1, 5, 13, 0, 0, 0};

        do_reset(100);
        chk("rst_wblk", WBLK, 0);
        chk("rst_nfree", NFREE, 15);
        chk("rst_full", FULL, 0);
        chk("rst_vld", RD_VLD, 0);
        chk("rst_blk", RD_BLK, 0);
        chk("rst_drop", LCT_DROP, 0);
        chk("rst_nom", L1A_NOMATCH, 0);

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].wr, tbl[i].lct, tbl[i].l1a, tbl[i].rdd, 0, "tbl");
            chk($sformatf("tbl%0d_wblk", i), WBLK, tbl[i].wblk);
            chk($sformatf("tbl%0d_nfree", i), NFREE, tbl[i].nfree);
            chk($sformatf("tbl%0d_vld", i), RD_VLD, tbl[i].vld);
            chk($sformatf("tbl%0d_drop", i), LCT_DROP, tbl[i].drop);
            chk($sformatf("tbl%0d_nom", i), L1A_NOMATCH, tbl[i].nom);
        end

        // LCT on block 5, early L1A misses, on-time L1A matches.
        do_reset(100);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "lat");
        chk("lat_wblk5", WBLK, 5);
        step(0, 1, 0, 0, 0, "lat");
        chk("lat_nfree", NFREE, 14);
        chk("lat_wblk6", WBLK, 6);
        idle(95, "lat");
        step(0, 0, 1, 0, 0, "lat");
        chk("lat_early_nom", L1A_NOMATCH, 1);
        chk("lat_early_vld", RD_VLD, 0);
        idle(1, "lat");
        step(0, 0, 1, 0, 0, "lat");
        chk("lat_vld", RD_VLD, 1);
        chk("lat_blk", RD_BLK, 5);
        chk("lat_nom", L1A_NOMATCH, 0);
        step(0, 0, 0, 1, 0, "lat");
        chk("lat_done_vld", RD_VLD, 0);
        chk("lat_done_nfree", NFREE, 15);

        // Unmatched LCT expires, late L1A finds nothing.
        do_reset(100);
        step(0, 1, 0, 0, 0, "exp");
        idle(102, "exp");
        step(0, 0, 0, 0, 0, "exp");
        chk("exp_t103_nfree", NFREE, 14);
        step(0, 0, 0, 0, 0, "exp");
        chk("exp_t104_nfree", NFREE, 15);
        idle(5, "exp");
        step(0, 0, 1, 0, 0, "exp");
        chk("exp_nom", L1A_NOMATCH, 1);
        step(0, 0, 0, 0, 0, "exp");
        chk("exp_nom_clr", L1A_NOMATCH, 0);

        // Fill every block, then overflow.
        do_reset(100);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, "full");
        chk("full_nfree", NFREE, 0);
        chk("full_flag", FULL, 1);
        chk("full_wblk", WBLK, 15);
        step(0, 1, 0, 0, 0, "full");
        chk("full_drop", LCT_DROP, 1);
        chk("full_drop_wblk", WBLK, 15);
        step(1, 0, 0, 0, 0, "full");
        chk("full_wr_wblk", WBLK, 15);
        chk("full_wr_nfree", NFREE, 0);
        chk("full_drop_clr", LCT_DROP, 0);

        // Readout of 3, expiry of 7 and an LCT in one cycle.
        do_reset(4);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "sim");
        step(0, 1, 0, 0, 0, "sim");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "sim");
        step(0, 1, 0, 0, 0, "sim");
        step(0, 0, 1, 0, 0, "sim");
        idle(6, "sim");
        chk("sim_pre_nfree", NFREE, 13);
        chk("sim_pre_blk", RD_BLK, 3);
        chk("sim_pre_wblk", WBLK, 8);
        step(0, 1, 0, 1, 0, "sim");
        chk("sim_nfree", NFREE, 14);
        chk("sim_wblk", WBLK, 9);
        chk("sim_vld", RD_VLD, 0);

        // Reset while two blocks wait for readout.
        do_reset(4);
        step(0, 1, 0, 0, 0, "rst2");
        step(0, 1, 0, 0, 0, "rst2");
        step(0, 0, 1, 0, 0, "rst2");
        step(0, 0, 1, 0, 0, "rst2");
        chk("rst2_pre_vld", RD_VLD, 1);
        chk("rst2_pre_blk", RD_BLK, 0);
        step(0, 0, 0, 0, 1, "rst2");
        chk("rst2_vld", RD_VLD, 0);
        chk("rst2_wblk", WBLK, 0);
        chk("rst2_nfree", NFREE, 15);

        // Random traffic; delay 2 exercises the saturated lower bound.
        for (int p = 0; p < 2; p++) begin
            do_reset(p == 0 ? 2 : 8);
            for (int c = 0; c < 2500; c++) begin
                step($urandom_range(0, 99) < 30,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 35,
                     $urandom_range(0, 399) == 0,
                     "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
